// File: rtl/sd_sector_addr_gen.sv
// Multi-channel SD sector address generator: FAT/data/raw sector addresses plus FAT cluster-chain following.
// Define SDADDR_FAT_MIRROR_EN to add the daddr2/daddr2_vld FAT2 mirror address outputs.
module sd_sector_addr_gen #(
    parameter int N_CH      = 4,
    parameter int AW        = 32,
    parameter int PW        = 16,
    parameter int SPC_MAX   = 7,
    parameter int ROOT_CLUS = 2,
    localparam int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ureset,
    input  logic [AW-1:0]  part_sa,
    input  logic [15:0]    fat_sa,
    input  logic [AW-1:0]  fat_size,
    input  logic [2:0]     spc_log2,
    input  logic           cmd_vld,
    output logic           cmd_rdy,
    input  logic [2:0]     cmd_op,
    input  logic [CHW-1:0] cmd_ch,
    input  logic [AW-1:0]  cmd_arg,
    input  logic           step,
    input  logic [CHW-1:0] step_ch,
    output logic [AW-1:0]  daddr,
    output logic           daddr_vld,
    output logic [PW-1:0]  ptr,
    output logic           clus_req,
    output logic [AW-1:0]  clus_cur,
    input  logic           clus_ack,
    input  logic [AW-1:0]  clus_nxt,
`ifdef SDADDR_FAT_MIRROR_EN
    output logic [AW-1:0]  daddr2,
    output logic           daddr2_vld,
`endif
    output logic           err
);

    localparam int          SW      = (SPC_MAX < 1) ? 1 : ((SPC_MAX > 7) ? 7 : SPC_MAX);
    localparam logic [2:0]  SPC_CAP = (SPC_MAX > 7) ? 3'd7 : 3'(SPC_MAX);
    localparam logic [AW-1:0] EOC   = AW'(32'h0FFF_FFF8);
    localparam logic [AW-1:0] ROOT  = AW'(ROOT_CLUS);

    typedef enum logic {
        ST_IDLE,
        ST_CLUS_WAIT
    } state_t;

    typedef enum logic [2:0] {
        OP_SET_CLUS  = 3'd0,
        OP_ADDR_FAT  = 3'd1,
        OP_ADDR_DATA = 3'd2,
        OP_ADDR_RAW  = 3'd3,
        OP_CLR_PTR   = 3'd4
    } op_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clus_q [N_CH];
    logic [AW-1:0]   clus_d [N_CH];
    logic [SW-1:0]   sic_q  [N_CH];
    logic [SW-1:0]   sic_d  [N_CH];
    logic [PW-1:0]   ptr_q  [N_CH];
    logic [PW-1:0]   ptr_d  [N_CH];
    logic [AW-1:0]   daddr_q, daddr_d;
    logic            dvld_q, dvld_d;
    logic            req_q, req_d;
    logic [AW-1:0]   cur_q, cur_d;
    logic [CHW-1:0]  wch_q, wch_d;
    logic            err_q, err_d;
`ifdef SDADDR_FAT_MIRROR_EN
    logic [AW-1:0]   daddr2_q, daddr2_d;
    logic            d2vld_q, d2vld_d;
`endif

    logic            cmd_ch_ok, step_ch_ok, step_lost;
    logic [2:0]      spc_eff;
    logic [SW-1:0]   sic_last;
    logic [AW-1:0]   clus_sel, fat_addr, data_addr;
    logic [SW-1:0]   sic_sel;

    assign cmd_ch_ok  = 32'(cmd_ch) < 32'(N_CH);
    assign step_ch_ok = 32'(step_ch) < 32'(N_CH);
    assign spc_eff    = (spc_log2 > SPC_CAP) ? SPC_CAP : spc_log2;
    assign sic_last   = SW'((32'd1 << spc_eff) - 32'd1);

    assign clus_sel  = cmd_ch_ok ? clus_q[cmd_ch] : '0;
    assign sic_sel   = cmd_ch_ok ? sic_q[cmd_ch] : '0;
    assign fat_addr  = part_sa + AW'(fat_sa) + cmd_arg;
    assign data_addr = part_sa + AW'(fat_sa) + (fat_size << 1)
                     + ((clus_sel - ROOT) << spc_eff) + AW'(sic_sel);

    always_comb begin
        state_d   = state_q;
        clus_d    = clus_q;
        sic_d     = sic_q;
        ptr_d     = ptr_q;
        daddr_d   = daddr_q;
        dvld_d    = dvld_q;
        req_d     = req_q;
        cur_d     = cur_q;
        wch_d     = wch_q;
        err_d     = err_q;
        step_lost = 1'b0;
`ifdef SDADDR_FAT_MIRROR_EN
        daddr2_d  = daddr2_q;
        d2vld_d   = d2vld_q;
`endif
        if (state_q == ST_IDLE) begin
            if (cmd_vld) begin
                case (cmd_op)
                    OP_SET_CLUS: begin
                        dvld_d = 1'b0;
                        if (cmd_ch_ok) begin
                            clus_d[cmd_ch] = cmd_arg;
                            sic_d[cmd_ch]  = '0;
                            ptr_d[cmd_ch]  = '0;
                            step_lost      = (step_ch == cmd_ch);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_CLR_PTR: begin
                        dvld_d = 1'b0;
                        if (cmd_ch_ok) begin
                            sic_d[cmd_ch] = '0;
                            ptr_d[cmd_ch] = '0;
                            step_lost     = (step_ch == cmd_ch);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_ADDR_FAT: begin
                        daddr_d = fat_addr;
                        dvld_d  = 1'b1;
                    end
                    OP_ADDR_RAW: begin
                        daddr_d = cmd_arg;
                        dvld_d  = 1'b1;
                    end
                    OP_ADDR_DATA: begin
                        dvld_d = 1'b1;
                        // Clusters below the first data cluster have no data region; fall back to partition start
                        if (!cmd_ch_ok || clus_sel < ROOT) begin
                            daddr_d = part_sa;
                            err_d   = 1'b1;
                        end else begin
                            daddr_d = data_addr;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
`ifdef SDADDR_FAT_MIRROR_EN
                if (cmd_op == OP_ADDR_FAT) begin
                    daddr2_d = fat_addr + fat_size;
                    d2vld_d  = 1'b1;
                end else if (cmd_op <= OP_CLR_PTR) begin
                    d2vld_d = 1'b0;
                end
`endif
            end
            if (step && step_ch_ok && !step_lost) begin
                ptr_d[step_ch] = ptr_q[step_ch] + PW'(1);
                if (sic_q[step_ch] == sic_last) begin
                    sic_d[step_ch] = '0;
                    state_d        = ST_CLUS_WAIT;
                    req_d          = 1'b1;
                    cur_d          = clus_q[step_ch];
                    wch_d          = step_ch;
                end else begin
                    sic_d[step_ch] = sic_q[step_ch] + SW'(1);
                end
            end
        end else begin
            if (step) begin
                err_d = 1'b1;
            end
            if (clus_ack) begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                if (clus_nxt >= EOC) begin
                    err_d = 1'b1;
                end else begin
                    clus_d[wch_q] = clus_nxt;
                end
            end
        end

        if (ureset) begin
            state_d = ST_IDLE;
            for (int unsigned i = 0; i < unsigned'(N_CH); i++) begin
                clus_d[i] = ROOT;
                sic_d[i]  = '0;
                ptr_d[i]  = '0;
            end
            daddr_d = '0;
            dvld_d  = 1'b0;
            req_d   = 1'b0;
            cur_d   = '0;
            wch_d   = '0;
            err_d   = 1'b0;
`ifdef SDADDR_FAT_MIRROR_EN
            daddr2_d = '0;
            d2vld_d  = 1'b0;
`endif
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            for (int unsigned i = 0; i < unsigned'(N_CH); i++) begin
                clus_q[i] <= ROOT;
                sic_q[i]  <= '0;
                ptr_q[i]  <= '0;
            end
            daddr_q <= '0;
            dvld_q  <= 1'b0;
            req_q   <= 1'b0;
            cur_q   <= '0;
            wch_q   <= '0;
            err_q   <= 1'b0;
`ifdef SDADDR_FAT_MIRROR_EN
            daddr2_q <= '0;
            d2vld_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            clus_q  <= clus_d;
            sic_q   <= sic_d;
            ptr_q   <= ptr_d;
            daddr_q <= daddr_d;
            dvld_q  <= dvld_d;
            req_q   <= req_d;
            cur_q   <= cur_d;
            wch_q   <= wch_d;
            err_q   <= err_d;
`ifdef SDADDR_FAT_MIRROR_EN
            daddr2_q <= daddr2_d;
            d2vld_q  <= d2vld_d;
`endif
        end
    end

    assign cmd_rdy   = (state_q == ST_IDLE);
    assign daddr     = daddr_q;
    assign daddr_vld = dvld_q;
    assign ptr       = cmd_ch_ok ? ptr_q[cmd_ch] : '0;
    assign clus_req  = req_q;
    assign clus_cur  = cur_q;
    assign err       = err_q;
`ifdef SDADDR_FAT_MIRROR_EN
    assign daddr2     = daddr2_q;
    assign daddr2_vld = d2vld_q;
`endif

endmodule

// File: tb/tb_sd_sector_addr_gen.sv
// Bench for sd_sector_addr_gen: directed vector table, hand-written corner sequences, randomized model check.
module tb_sd_sector_addr_gen;

    localparam logic [2:0] SET = 3'd0, FAT = 3'd1, DAT = 3'd2, RAW = 3'd3, CLR = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ureset = 1'b0;
    logic [31:0] part_sa = 32'h2000;
    logic [15:0] fat_sa = 16'h20;
    logic [31:0] fat_size = 32'h400;
    logic [2:0]  spc_log2 = 3'd3;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [2:0]  cmd_op = 3'd0;
    logic [1:0]  cmd_ch = 2'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic        step = 1'b0;
    logic [1:0]  step_ch = 2'd0;
    logic [31:0] daddr;
    logic        daddr_vld;
    logic [15:0] ptr;
    logic        clus_req;
    logic [31:0] clus_cur;
    logic        clus_ack = 1'b0;
    logic [31:0] clus_nxt = 32'd0;
    logic        err;
`ifdef SDADDR_FAT_MIRROR_EN
    logic [31:0] daddr2;
    logic        daddr2_vld;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sd_sector_addr_gen #(.N_CH(4), .AW(32), .PW(16), .SPC_MAX(7), .ROOT_CLUS(2)) dut (
        .clk(clk), .reset(reset), .ureset(ureset),
        .part_sa(part_sa), .fat_sa(fat_sa), .fat_size(fat_size), .spc_log2(spc_log2),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_arg(cmd_arg),
        .step(step), .step_ch(step_ch),
        .daddr(daddr), .daddr_vld(daddr_vld), .ptr(ptr),
        .clus_req(clus_req), .clus_cur(clus_cur), .clus_ack(clus_ack), .clus_nxt(clus_nxt),
`ifdef SDADDR_FAT_MIRROR_EN
        .daddr2(daddr2), .daddr2_vld(daddr2_vld),
`endif
        .err(err)
    );

    typedef struct {
        logic        ur;
        logic        cv;
        logic [2:0]  op;
        logic [1:0]  ch;
        logic [31:0] arg;
        logic        st;
        logic [1:0]  sch;
        logic        ack;
        logic [31:0] nxt;
        logic [31:0] e_daddr;
        logic        e_vld;
        logic        e_rdy;
        logic        e_req;
        logic [31:0] e_cur;
        logic        e_err;
        logic [15:0] e_ptr;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: sector-in-cluster is derived as ptr mod sectors-per-cluster
    logic [31:0] m_clus [4];
    logic [15:0] m_ptr  [4];
    logic [31:0] m_daddr, m_cur;
    logic        m_vld, m_req, m_err, m_wait;
    logic [1:0]  m_wch;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic ur, input logic cv, input logic [2:0] op, input logic [1:0] ch,
                       input logic [31:0] arg, input logic st, input logic [1:0] sch, input logic ack,
                       input logic [31:0] nxt, input logic [31:0] ed, input logic ev, input logic erdy,
                       input logic ereq, input logic [31:0] ecur, input logic eerr, input logic [15:0] eptr);
        vec_t v;
        v = '{ur, cv, op, ch, arg, st, sch, ack, nxt, ed, ev, erdy, ereq, ecur, eerr, eptr};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic ur, input logic cv, input logic [2:0] op, input logic [1:0] ch,
                         input logic [31:0] arg, input logic st, input logic [1:0] sch,
                         input logic ack, input logic [31:0] nxt);
        ureset = ur; cmd_vld = cv; cmd_op = op; cmd_ch = ch; cmd_arg = arg;
        step = st; step_ch = sch; clus_ack = ack; clus_nxt = nxt;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_clus[i] = 32'd2;
            m_ptr[i]  = 16'd0;
        end
        m_daddr = 0; m_cur = 0; m_vld = 0; m_req = 0; m_err = 0; m_wait = 0; m_wch = 0;
    endtask

    task automatic model_step(input logic ur, input logic cv, input logic [2:0] op, input logic [1:0] ch,
                              input logic [31:0] arg, input logic st, input logic [1:0] sch,
                              input logic ack, input logic [31:0] nxt);
        int unsigned spc_n;
        longint unsigned a;
        logic lost;
        spc_n = 32'd1 << spc_log2;
        lost = 1'b0;
        if (ur) begin
            model_reset();
        end else if (!m_wait) begin
            if (cv) begin
                case (op)
                    SET: begin m_clus[ch] = arg; m_ptr[ch] = 0; m_vld = 0; lost = st && (sch == ch); end
                    CLR: begin m_ptr[ch] = 0; m_vld = 0; lost = st && (sch == ch); end
                    FAT: begin m_daddr = part_sa + {16'd0, fat_sa} + arg; m_vld = 1; end
                    RAW: begin m_daddr = arg; m_vld = 1; end
                    DAT: begin
                        m_vld = 1;
                        if (m_clus[ch] < 2) begin
                            m_daddr = part_sa;
                            m_err = 1;
                        end else begin
                            a = 64'(part_sa) + 64'(fat_sa) + 2 * 64'(fat_size)
                              + (64'(m_clus[ch]) - 2) * 64'(spc_n) + 64'(32'(m_ptr[ch]) % spc_n);
                            m_daddr = a[31:0];
                        end
                    end
                    default: m_err = 1;
                endcase
            end
            if (st && !lost) begin
                if ((32'(m_ptr[sch]) % spc_n) == spc_n - 1) begin
                    m_wait = 1; m_req = 1; m_cur = m_clus[sch]; m_wch = sch;
                end
                m_ptr[sch] = m_ptr[sch] + 16'd1;
            end
        end else begin
            if (st) m_err = 1;
            if (ack) begin
                m_wait = 0; m_req = 0;
                if (nxt >= 32'h0FFF_FFF8) m_err = 1;
                else m_clus[m_wch] = nxt;
            end
        end
    endtask

    initial begin
        // T1..T5 directed table (part_sa=0x2000, fat_sa=0x20, fat_size=0x400, spc_log2=3)
        add(0,1,FAT,0,5,        0,0,0,0,             32'h2025,0+1,1,0,0,0,0);
        add(0,1,SET,1,5,        0,0,0,0,             32'h2025,0,1,0,0,0,0);
        add(0,1,DAT,1,0,        0,0,0,0,             32'h2838,1,1,0,0,0,0);
        for (int k = 1; k <= 7; k++)
            add(0,0,SET,1,0,    1,1,0,0,             32'h2838,1,1,0,0,0,16'(k));
        add(0,0,SET,1,0,        1,1,0,0,             32'h2838,1,0,1,5,0,8);
        add(0,1,RAW,1,32'hDEAD, 0,1,0,0,             32'h2838,1,0,1,5,0,8);
        add(0,0,SET,1,0,        0,1,1,9,             32'h2838,1,1,0,5,0,8);
        add(0,1,DAT,1,0,        0,1,0,0,             32'h2858,1,1,0,5,0,8);
        for (int k = 1; k <= 7; k++)
            add(0,0,SET,1,0,    1,1,0,0,             32'h2858,1,1,0,5,0,16'(8 + k));
        add(0,0,SET,1,0,        1,1,0,0,             32'h2858,1,0,1,9,0,16);
        add(0,0,SET,1,0,        1,1,0,0,             32'h2858,1,0,1,9,1,16);
        add(0,0,SET,1,0,        0,1,1,32'h0FFFFFF8,  32'h2858,1,1,0,9,1,16);
        add(0,1,DAT,1,0,        0,1,0,0,             32'h2858,1,1,0,9,1,16);
        add(1,1,FAT,1,1,        1,1,0,0,             32'h0,0,1,0,0,0,0);
        add(0,1,DAT,3,0,        0,0,0,0,             32'h2820,1,1,0,0,0,0);
        add(0,0,SET,0,0,        1,0,0,0,             32'h2820,1,1,0,0,0,1);
        add(0,1,SET,0,3,        1,0,0,0,             32'h2820,0,1,0,0,0,0);
        add(0,1,DAT,0,0,        0,0,0,0,             32'h2828,1,1,0,0,0,0);
        add(0,0,SET,0,0,        1,0,0,0,             32'h2828,1,1,0,0,0,1);
        add(0,1,DAT,0,0,        1,0,0,0,             32'h2829,1,1,0,0,0,2);
        add(0,1,DAT,0,0,        0,0,0,0,             32'h282A,1,1,0,0,0,2);
        add(0,1,RAW,0,32'h12345678, 0,0,0,0,         32'h12345678,1,1,0,0,0,2);
        add(0,1,CLR,0,0,        1,0,0,0,             32'h12345678,0,1,0,0,0,0);
        add(0,1,DAT,0,0,        0,0,0,0,             32'h2828,1,1,0,0,0,0);
        add(0,1,SET,1,4,        1,0,0,0,             32'h2828,0,1,0,0,0,0);
        add(0,0,SET,0,0,        0,0,0,0,             32'h2828,0,1,0,0,0,1);
        add(0,1,3'd5,0,0,       0,0,0,0,             32'h2828,0,1,0,0,1,1);
        add(1,0,SET,0,0,        0,0,0,0,             32'h0,0,1,0,0,0,0);
        add(0,1,SET,2,1,        0,0,0,0,             32'h0,0,1,0,0,0,0);
        add(0,1,DAT,2,0,        0,0,0,0,             32'h2000,1,1,0,0,1,0);
        add(1,0,SET,0,0,        0,0,0,0,             32'h0,0,1,0,0,0,0);
        add(0,1,DAT,0,0,        0,0,1,7,             32'h2820,1,1,0,0,0,0);
        add(0,1,DAT,0,0,        0,0,0,0,             32'h2820,1,1,0,0,0,0);

        #2;
        chk("rst.daddr", daddr, 0);
        chk("rst.vld", daddr_vld, 0);
        chk("rst.rdy", cmd_rdy, 1);
        chk("rst.req", clus_req, 0);
        chk("rst.cur", clus_cur, 0);
        chk("rst.err", err, 0);
        chk("rst.ptr", ptr, 0);
        #11 reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].ur, vecs[i].cv, vecs[i].op, vecs[i].ch, vecs[i].arg,
                  vecs[i].st, vecs[i].sch, vecs[i].ack, vecs[i].nxt);
            tick();
            chk($sformatf("v%0d.daddr", i), daddr, vecs[i].e_daddr);
            chk($sformatf("v%0d.vld", i), daddr_vld, vecs[i].e_vld);
            chk($sformatf("v%0d.rdy", i), cmd_rdy, vecs[i].e_rdy);
            chk($sformatf("v%0d.req", i), clus_req, vecs[i].e_req);
            chk($sformatf("v%0d.cur", i), clus_cur, vecs[i].e_cur);
            chk($sformatf("v%0d.err", i), err, vecs[i].e_err);
            chk($sformatf("v%0d.ptr", i), ptr, vecs[i].e_ptr);
        end

        // Asynchronous reset while waiting on the FAT engine
        drive(1,0,SET,0,0,0,0,0,0); tick();
        for (int k = 0; k < 8; k++) begin
            drive(0,0,SET,0,0,1,0,0,0); tick();
        end
        drive(0,0,SET,0,0,0,0,0,0);
        chk("arst.pre_req", clus_req, 1);
        chk("arst.pre_rdy", cmd_rdy, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst.req", clus_req, 0);
        chk("arst.rdy", cmd_rdy, 1);
        chk("arst.ptr", ptr, 0);
        #1 reset = 1'b1;
        drive(0,1,DAT,0,0,0,0,0,0); tick();
        chk("arst.daddr", daddr, 32'h2820);

`ifdef SDADDR_FAT_MIRROR_EN
        drive(0,1,FAT,0,5,0,0,0,0); tick();
        chk("mir.daddr2", daddr2, 32'h2425);
        chk("mir.vld2", daddr2_vld, 1);
        drive(0,1,RAW,0,7,0,0,0,0); tick();
        chk("mir.vld2_clr", daddr2_vld, 0);
`endif

        // Randomized phase against the reference model
        for (int p = 0; p < 4; p++) begin
            logic [2:0] spc_tab [4];
            spc_tab = '{3'd3, 3'd0, 3'd7, 3'd1};
            spc_log2 = spc_tab[p];
            part_sa  = $urandom();
            fat_sa   = 16'($urandom());
            fat_size = $urandom();
            drive(1,0,SET,0,0,0,0,0,0);
            model_reset();
            tick();
            for (int c = 0; c < 500; c++) begin
                logic        ur, cv, st, ack;
                logic [2:0]  op;
                logic [1:0]  ch, sch;
                logic [31:0] arg, nxt;
                int unsigned r;
                ur  = ($urandom_range(0, 199) == 0);
                cv  = 1'($urandom_range(0, 1));
                r   = $urandom_range(0, 99);
                op  = (r < 3) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                ch  = 2'($urandom_range(0, 3));
                arg = (op == SET) ? (($urandom_range(0, 9) == 0) ? $urandom() : $urandom_range(0, 20))
                                  : $urandom();
                st  = ($urandom_range(0, 99) < 45);
                sch = 2'($urandom_range(0, 3));
                ack = ($urandom_range(0, 3) == 0);
                nxt = ($urandom_range(0, 9) == 0) ? 32'h0FFF_FFF8 + $urandom_range(0, 7)
                                                  : $urandom_range(0, 40);
                drive(ur, cv, op, ch, arg, st, sch, ack, nxt);
                model_step(ur, cv, op, ch, arg, st, sch, ack, nxt);
                tick();
                chk("rnd.daddr", daddr, m_daddr);
                chk("rnd.vld", daddr_vld, m_vld);
                chk("rnd.rdy", cmd_rdy, !m_wait);
                chk("rnd.req", clus_req, m_req);
                chk("rnd.cur", clus_cur, m_cur);
                chk("rnd.err", err, m_err);
                chk("rnd.ptr", ptr, m_ptr[ch]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
